// File: rtl/ps2_decoder_pkg.sv
// ps2_decoder_pkg: PS/2 prefix and ignored-byte constants, decoder state and event record types
package ps2_decoder_pkg;
  localparam logic [7:0] SC_E0       = 8'hE0;
  localparam logic [7:0] SC_F0       = 8'hF0;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
  localparam logic [7:0] SC_ECHO     = 8'hEE;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } evt_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {SC_BAT_OK, SC_ACK, SC_BAT_FAIL, SC_ECHO, SC_RESEND, SC_PAUSE};
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: power-of-two event FIFO; a push into a full FIFO only lands alongside a pop
module ps2_event_fifo
  import ps2_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  evt_t                            din_i,
  output evt_t                            dout_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  evt_t          mem_q [FIFO_DEPTH];

  assign full_o  = cnt_q == CW'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | pop_i);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end

  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: E0/F0 prefix decoder feeding an event FIFO; define PS2_REPEAT_FILTER_EN to drop typematic repeats
module ps2_scancode_decoder
  import ps2_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [7:0]                      ps2_key_data,
  input  logic                            ps2_key_pressed,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [7:0]                      evt_code,
  output logic                            evt_extended,
  output logic                            evt_release,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);
  state_e state_q, state_d;
  logic   push_q, push_d, ovf_q, ovf_d;
  evt_t   evt_q, ev, head;
  logic   emit, hold, fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ev      = {state_q inside {GOT_E0, GOT_E0F0}, state_q inside {GOT_F0, GOT_E0F0}, ps2_key_data};
    if (ps2_key_pressed) begin
      if (ps2_key_data == SC_E0) state_d = GOT_E0;
      else if (ps2_key_data == SC_F0) state_d = (state_q inside {GOT_E0, GOT_E0F0}) ? GOT_E0F0 : GOT_F0;
      else if (!(state_q == IDLE && is_ignored(ps2_key_data))) begin
        state_d = IDLE;
        emit    = 1'b1;
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       rep_vld_q, rep_vld_d, key_match;
  logic [8:0] rep_key_q, rep_key_d;

  assign key_match = rep_vld_q && rep_key_q == {ev.ext, ev.code};

  always_comb begin
    rep_vld_d = rep_vld_q;
    rep_key_d = rep_key_q;
    hold      = 1'b0;
    if (emit && !ev.rel) begin
      hold      = key_match;
      rep_vld_d = 1'b1;
      rep_key_d = {ev.ext, ev.code};
    end else if (emit && key_match) rep_vld_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      rep_vld_q <= 1'b0;
      rep_key_q <= '0;
    end else begin
      rep_vld_q <= rep_vld_d;
      rep_key_q <= rep_key_d;
    end
`else
  assign hold = 1'b0;
`endif

  assign push_d = emit & ~hold;
  // pop is effective whenever the FIFO is full, so a full push drops only without ready
  assign ovf_d  = ovf_q | (push_q & fifo_full & ~evt_ready);

  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      evt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      evt_q   <= ev;
      ovf_q   <= ovf_d;
    end

  ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .push_i (push_q),
    .pop_i  (evt_ready),
    .din_i  (evt_q),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign evt_valid                               = ~fifo_empty;
  assign {evt_extended, evt_release, evt_code}   = fifo_empty ? 10'd0 : head;
  assign overflow                                = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed and randomized checks against a prefix-flag and queue reference model
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b0, pressed = 1'b0, ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid, ext, rel, ovf;
  logic [7:0] code;
  logic [2:0] count;
  int         n_tests = 0, n_fail = 0;

  logic [9:0] m_q[$];
  logic       m_pv, m_ext, m_rel, m_ovf, m_rv;
  logic [9:0] m_pe;
  logic [8:0] m_rk;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50       (clk),
    .reset          (rst),
    .ps2_key_data   (data),
    .ps2_key_pressed(pressed),
    .evt_valid      (valid),
    .evt_ready      (ready),
    .evt_code       (code),
    .evt_extended   (ext),
    .evt_release    (rel),
    .fifo_count     (count),
    .overflow       (ovf)
  );

  function automatic logic [9:0] m_head();
    return m_q.size() > 0 ? m_q[0] : 10'd0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    {m_pv, m_ext, m_rel, m_ovf, m_rv} = '0;
    m_pe = '0;
    m_rk = '0;
  endtask

  // Prefixes are tracked as two flags: E0 restarts a sequence, F0 marks a break.
  task automatic model_edge(input logic p, input logic [7:0] d, input logic r);
    logic       sup;
    logic [9:0] e;
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pv) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pe);
      else m_ovf = 1'b1;
    end
    m_pv = 1'b0;
    if (p) begin
      if (d == 8'hE0) begin
        m_ext = 1'b1;
        m_rel = 1'b0;
      end else if (d == 8'hF0) m_rel = 1'b1;
      else if (!m_ext && !m_rel && d inside {8'hAA, 8'hFA, 8'hFC, 8'hEE, 8'hFE, 8'hE1}) begin
      end else begin
        e   = {m_ext, m_rel, d};
        sup = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        if (!m_rel) begin
          if (m_rv && m_rk == {m_ext, d}) sup = 1'b1;
          m_rv = 1'b1;
          m_rk = {m_ext, d};
        end else if (m_rv && m_rk == {m_ext, d}) m_rv = 1'b0;
`endif
        m_ext = 1'b0;
        m_rel = 1'b0;
        if (!sup) begin
          m_pv = 1'b1;
          m_pe = e;
        end
      end
    end
  endtask

  task automatic step(input logic p, input logic [7:0] d, input logic r);
    @(negedge clk);
    pressed = p;
    data    = d;
    ready   = r;
    @(posedge clk);
    model_edge(p, d, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    pressed = 1'b0;
    ready   = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({valid, count, ovf, ext, rel, code} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {valid, count, ovf, ext, rel, code});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    step(1'b1, 8'h1C, 1'b1);
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: valid %b required 0", valid);
    end
    step(1'b0, 8'h00, 1'b1);
    n_tests++;
    if ({valid, ext, rel, code} !== {1'b1, 2'b00, 8'h1C}) begin
      n_fail++;
      $display("FAIL single_event: got %h required %h", {valid, ext, rel, code}, {1'b1, 2'b00, 8'h1C});
    end
    step(1'b0, 8'h00, 1'b1);
    n_tests++;
    if ({valid, count} !== 4'd0) begin
      n_fail++;
      $display("FAIL single_pulse: valid %b count %0d required 0 0", valid, count);
    end
  endtask

  task automatic test_extended();
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL ext_prefix_no_event: count %0d required 0", count);
    end
    step(1'b1, 8'h75, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({count, ext, rel, code} !== {3'd1, 2'b11, 8'h75}) begin
      n_fail++;
      $display("FAIL ext_break: got %h required %h", {count, ext, rel, code}, {3'd1, 2'b11, 8'h75});
    end
    step(1'b0, 8'h00, 1'b1);
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_drain: valid %b required 0", valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bs[5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    for (int i = 0; i < 5; i++) step(1'b1, bs[i], 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({count, ovf, code} !== {3'd4, 1'b1, 8'h15}) begin
      n_fail++;
      $display("FAIL overflow_full: got %h required %h", {count, ovf, code}, {3'd4, 1'b1, 8'h15});
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({valid, code} !== {1'b1, bs[i]}) begin
        n_fail++;
        $display("FAIL overflow_drain%0d: got %h required %h", i, {valid, code}, {1'b1, bs[i]});
      end
      step(1'b0, 8'h00, 1'b1);
    end
    n_tests++;
    if ({count, ovf} !== {3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %h required %h", {count, ovf}, {3'd0, 1'b1});
    end
    do_reset();
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_reset: ovf %b required 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] bs[5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, bs[i], 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, bs[4], 1'b0);
    step(1'b0, 8'h00, 1'b1);
    n_tests++;
    if ({count, ovf, code} !== {3'd4, 1'b0, 8'h1E}) begin
      n_fail++;
      $display("FAIL full_push_pop: got %h required %h", {count, ovf, code}, {3'd4, 1'b0, 8'h1E});
    end
    for (int i = 1; i < 5; i++) begin
      n_tests++;
      if ({valid, code} !== {1'b1, bs[i]}) begin
        n_fail++;
        $display("FAIL full_order%0d: got %h required %h", i, {valid, code}, {1'b1, bs[i]});
      end
      step(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] seq[5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    int         makes = 0, rels = 0, exp_makes;
    logic [9:0] last = '0;
`ifdef PS2_REPEAT_FILTER_EN
    exp_makes = 1;
`else
    exp_makes = 3;
`endif
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i < 5, i < 5 ? seq[i] : 8'h00, 1'b1);
      if (valid) begin
        last = {ext, rel, code};
        if (rel) rels++;
        else makes++;
      end
    end
    n_tests++;
    if (makes !== exp_makes || rels !== 1) begin
      n_fail++;
      $display("FAIL repeat_counts: makes %0d releases %0d required %0d 1", makes, rels, exp_makes);
    end
    n_tests++;
    if (last !== {2'b01, 8'h1C}) begin
      n_fail++;
      $display("FAIL repeat_last: got %h required %h", last, {2'b01, 8'h1C});
    end
  endtask

  task automatic test_reset_mid_prefix();
    do_reset();
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'hE0, 1'b0);
    @(negedge clk);
    pressed = 1'b0;
    rst     = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({valid, count, ovf, ext, rel, code} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h required 0", {valid, count, ovf, ext, rel, code});
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({valid, count, ovf, ext, rel, code} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %h required 0", {valid, count, ovf, ext, rel, code});
    end
    @(negedge clk);
    rst     = 1'b0;
    pressed = 1'b1;
    data    = 8'h74;
    @(posedge clk);
    model_edge(1'b1, 8'h74, 1'b0);
    #1;
    step(1'b0, 8'h00, 1'b0);
    n_tests++;
    if ({count, ext, rel, code} !== {3'd1, 2'b00, 8'h74}) begin
      n_fail++;
      $display("FAIL reset_prefix_discard: got %h required %h", {count, ext, rel, code}, {3'd1, 2'b00, 8'h74});
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[9] = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h1C, 8'h1C, 8'h75, 8'h74, 8'hE1};
    logic [7:0] b;
    logic       r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 9) == 9) ? 8'($urandom) : pool[$urandom_range(0, 8)];
      r = ((i / 60) % 3 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), b, r);
      n_tests++;
      if ({valid, count, ovf} !== {m_q.size() > 0, 3'(m_q.size()), m_ovf}) begin
        n_fail++;
        $display("FAIL rand_status@%0d: got %b required %b", i, {valid, count, ovf}, {m_q.size() > 0, 3'(m_q.size()), m_ovf});
      end
      n_tests++;
      if ({ext, rel, code} !== m_head()) begin
        n_fail++;
        $display("FAIL rand_head@%0d: got %h required %h", i, {ext, rel, code}, m_head());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_extended();
    test_overflow();
    test_full_push_pop();
    test_repeat();
    test_reset_mid_prefix();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
